ped_crossing_ctrl: RTL and testbench
====================================

// Module: ped_crossing_ctrl
// PURPOSE
//  Downstream consumer of the traffic_light output tf (trafic_light_t, traffic_light_pkg).
//  Latches pedestrian button requests and grants a WALK phase only on entry into RED.
//  Counts the WALK and flashing DONT_WALK phases on an external tick enable.
//  Drives hold_red back upstream so the light keeps RED until the crossing clears.
// PARAMETERS
//  WALK_TICKS   8   ticks with walk lamp on; legal range 1..2**CNT_W-1
//  FLASH_TICKS  6   ticks of flashing dont_walk; legal range 1..2**CNT_W-1
//  CNT_W        4   width of the countdown register and the remaining port
// PORTS
//  clk              in   1      system clock; all logic on the rising edge
//  syn_reset        in   1      synchronous reset, active-high
//  tf               in   2      current light, trafic_light_t (RED/YELLOW/GREEN)
//  tick             in   1      1-cycle phase-count enable from the prescaler
//  ped_button       in   1      raw asynchronous button level
//  walk             out  1      walk lamp
//  dont_walk        out  1      dont-walk lamp (solid or flashing)
//  ped_req_pending  out  1      request latched, not yet served
//  hold_red         out  1      asks the light to stay RED
//  conflict         out  1      1-cycle pulse when tf leaves RED during WALK/FLASH
//  remaining        out  CNT_W  ticks left in the current phase; 0 otherwise
// BEHAVIOUR
//  Reset (clk edge with syn_reset=1), outputs after the edge:
//   walk=0, dont_walk=1, ped_req_pending=0, hold_red=0, conflict=0, remaining=0.
//   Reset also clears the sync flops and prev_tf (prev_tf resets to RED).
//   Reset overrides every other event, including mid-WALK/FLASH.
//  Button: 2-flop synchroniser, then rising-edge detect.
//   The edge sets req on the next clk edge.
//   ped_req_pending is therefore high after the 3rd rising clk edge following ped_button rising.
//   A held button produces one request only.
//  red_entry = (tf==RED) && (prev_tf!=RED). prev_tf is registered every cycle.
//  FSM states, ped_state_t:
//   P_IDLE:
//     dont_walk=1.
//     If req && red_entry: go to P_WALK, remaining<=WALK_TICKS, req<=0.
//     Otherwise stay. A request seen during RED waits for the next red_entry.
//   P_WALK:
//     walk=1, dont_walk=0, hold_red=1.
//     On tick: remaining decrements.
//     On tick with remaining==1: go to P_FLASH, remaining<=FLASH_TICKS, flash<=1.
//   P_FLASH:
//     walk=0, dont_walk=flash, hold_red=1.
//     On each tick: flash toggles and remaining decrements.
//     On tick with remaining==1: go to P_IDLE, remaining<=0.
//  Abort: tf!=RED while in P_WALK or P_FLASH.
//   Go to P_IDLE next edge and pulse conflict for 1 cycle. remaining<=0.
//   Abort has priority over tick in the same cycle.
//  Button edge during WALK/FLASH sets req; it is served at the next red_entry.
//  Button edge in the same cycle as the IDLE->WALK grant is absorbed; req ends 0.
//  Outputs are registered, decoded from state/flash. No combinational path from tf to outputs.
//  tick with no active phase is ignored. remaining never wraps below 0.
// STRUCTURE
//  traffic_light_pkg gains:
//   ped_state_t enum {P_IDLE, P_WALK, P_FLASH}, 2-bit.
//   Lamp-pattern constants.
//  Sub-module btn_sync_edge (2-flop sync + rising-edge pulse).
//   Ports: clk, syn_reset, d_async, rise.
//  Elaboration-time assertion on WALK_TICKS/FLASH_TICKS range.
// TESTING
//  1 Reset: syn_reset=1 for 2 cycles -> walk=0, dont_walk=1, remaining=0, hold_red=0.
//  2 Grant: press during GREEN, then tf=RED.
//    -> pending=1 after 3 edges; on the edge after red_entry walk=1, remaining=8, pending=0.
//  3 Countdown: 8 ticks -> FLASH with remaining=6; dont_walk toggles per tick.
//    After 6 more ticks -> P_IDLE, dont_walk=1.
//  4 Abort: tf=GREEN at remaining=5 in WALK, tick in the same cycle.
//    -> conflict pulse 1 cycle, P_IDLE, remaining=0.
//  5 Re-request: press during FLASH -> pending=1, not served until tf leaves and re-enters RED.
//    Button held 50 cycles -> one request only.
//  6 Grant/edge collision and mid-WALK syn_reset.
//    -> pending=0 after grant; after reset all outputs equal their reset values.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared types for the traffic light and its pedestrian-crossing consumer.
package traffic_light_pkg;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2
   } trafic_light_t;

   typedef enum logic [1:0] {
      P_IDLE  = 2'd0,
      P_WALK  = 2'd1,
      P_FLASH = 2'd2
   } ped_state_t;

   typedef struct packed {
      logic walk;
      logic dont_walk;
      logic hold_red;
   } lamp_t;

   localparam lamp_t LAMP_IDLE      = '{walk: 1'b0, dont_walk: 1'b1, hold_red: 1'b0};
   localparam lamp_t LAMP_WALK      = '{walk: 1'b1, dont_walk: 1'b0, hold_red: 1'b1};
   localparam lamp_t LAMP_FLASH_ON  = '{walk: 1'b0, dont_walk: 1'b1, hold_red: 1'b1};
   localparam lamp_t LAMP_FLASH_OFF = '{walk: 1'b0, dont_walk: 1'b0, hold_red: 1'b1};

endpackage

// File: rtl/ped_crossing_ctrl_btn_sync.sv
// Two-flop synchroniser for the raw button level plus a one-cycle rising-edge pulse.
module btn_sync_edge (
   input  logic clk,
   input  logic syn_reset,
   input  logic d_async,
   output logic rise
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk) begin
      if (syn_reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= d_async;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Edge is decoded straight from flops so the request latches one edge later.
   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: grants WALK on RED entry, counts WALK/FLASH on tick.
module ped_crossing_ctrl
   import traffic_light_pkg::*;
#(
   parameter int unsigned WALK_TICKS  = 8,
   parameter int unsigned FLASH_TICKS = 6,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             syn_reset,
   input  trafic_light_t    tf,
   input  logic             tick,
   input  logic             ped_button,
   output logic             walk,
   output logic             dont_walk,
   output logic             ped_req_pending,
   output logic             hold_red,
   output logic             conflict,
   output logic [CNT_W-1:0] remaining
);

   localparam int unsigned MAX_TICKS = (32'd1 << CNT_W) - 32'd1;

   if (WALK_TICKS < 1 || WALK_TICKS > MAX_TICKS) begin : g_walk_range
      $error("WALK_TICKS out of range for CNT_W");
   end
   if (FLASH_TICKS < 1 || FLASH_TICKS > MAX_TICKS) begin : g_flash_range
      $error("FLASH_TICKS out of range for CNT_W");
   end

   ped_state_t       state_q, state_d;
   trafic_light_t    prev_tf_q;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             flash_q, flash_d;
   logic             req_q, req_d;
   logic             conflict_q, conflict_d;
   lamp_t            lamp_q, lamp_d;
   logic             rise;
   logic             grant;
   logic             tf_red;
   logic             red_entry;

   btn_sync_edge u_btn (
      .clk       (clk),
      .syn_reset (syn_reset),
      .d_async   (ped_button),
      .rise      (rise)
   );

   assign tf_red    = (tf == RED);
   assign red_entry = tf_red && (prev_tf_q != RED);

   always_ff @(posedge clk) begin
      if (syn_reset) begin
         state_q    <= P_IDLE;
         prev_tf_q  <= RED;
         rem_q      <= '0;
         flash_q    <= 1'b0;
         req_q      <= 1'b0;
         conflict_q <= 1'b0;
         lamp_q     <= LAMP_IDLE;
      end else begin
         state_q    <= state_d;
         prev_tf_q  <= tf;
         rem_q      <= rem_d;
         flash_q    <= flash_d;
         req_q      <= req_d;
         conflict_q <= conflict_d;
         lamp_q     <= lamp_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      flash_d    = flash_q;
      req_d      = req_q;
      conflict_d = 1'b0;
      grant      = 1'b0;
      lamp_d     = LAMP_IDLE;

      unique case (state_q)
         P_IDLE: begin
            if (req_q && red_entry) begin
               state_d = P_WALK;
               rem_d   = CNT_W'(WALK_TICKS);
               grant   = 1'b1;
            end
         end
         P_WALK: begin
            // Leaving RED mid-crossing wins over a same-cycle tick.
            if (!tf_red) begin
               state_d    = P_IDLE;
               rem_d      = '0;
               conflict_d = 1'b1;
            end else if (tick) begin
               if (rem_q <= CNT_W'(1)) begin
                  state_d = P_FLASH;
                  rem_d   = CNT_W'(FLASH_TICKS);
                  flash_d = 1'b1;
               end else begin
                  rem_d = rem_q - CNT_W'(1);
               end
            end
         end
         P_FLASH: begin
            if (!tf_red) begin
               state_d    = P_IDLE;
               rem_d      = '0;
               flash_d    = 1'b0;
               conflict_d = 1'b1;
            end else if (tick) begin
               flash_d = ~flash_q;
               if (rem_q <= CNT_W'(1)) begin
                  state_d = P_IDLE;
                  rem_d   = '0;
                  flash_d = 1'b0;
               end else begin
                  rem_d = rem_q - CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = P_IDLE;
            rem_d   = '0;
            flash_d = 1'b0;
         end
      endcase

      // A button edge coinciding with the grant is absorbed by it.
      if (rise)  req_d = 1'b1;
      if (grant) req_d = 1'b0;

      unique case (state_d)
         P_WALK:  lamp_d = LAMP_WALK;
         P_FLASH: lamp_d = flash_d ? LAMP_FLASH_ON : LAMP_FLASH_OFF;
         default: lamp_d = LAMP_IDLE;
      endcase
   end

   assign walk            = lamp_q.walk;
   assign dont_walk       = lamp_q.dont_walk;
   assign hold_red        = lamp_q.hold_red;
   assign ped_req_pending = req_q;
   assign conflict        = conflict_q;
   assign remaining       = rem_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with an expected-output scoreboard queue.
module tb_ped_crossing_ctrl;
   import traffic_light_pkg::*;

   logic          clk;
   logic          syn_reset;
   trafic_light_t tf;
   logic          tick;
   logic          ped_button;
   logic          walk, dont_walk, ped_req_pending, hold_red, conflict;
   logic [3:0]    remaining;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [8:0] val;
   } exp_t;

   exp_t sb[$];

   ped_crossing_ctrl #(.WALK_TICKS(8), .FLASH_TICKS(6), .CNT_W(4)) dut (
      .clk             (clk),
      .syn_reset       (syn_reset),
      .tf              (tf),
      .tick            (tick),
      .ped_button      (ped_button),
      .walk            (walk),
      .dont_walk       (dont_walk),
      .ped_req_pending (ped_req_pending),
      .hold_red        (hold_red),
      .conflict        (conflict),
      .remaining       (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Push expectation, advance one edge, then pop and compare.
   task automatic chk(input string tag, input logic w, input logic dw, input logic p,
                      input logic h, input logic c, input logic [3:0] r);
      exp_t       e;
      exp_t       got;
      logic [8:0] obs;
      e.tag = tag;
      e.val = {w, dw, p, h, c, r};
      sb.push_back(e);
      cyc();
      got = sb.pop_front();
      obs = {walk, dont_walk, ped_req_pending, hold_red, conflict, remaining};
      checks++;
      assert (obs === got.val)
      else begin
         errors++;
         $error("FAIL %s: observed w/dw/pend/hold/conf/rem=%b expected %b", got.tag, obs, got.val);
      end
   endtask

   initial begin
      syn_reset  = 1'b1;
      tf         = GREEN;
      tick       = 1'b0;
      ped_button = 1'b0;
      cyc();
      chk("reset", 0, 1, 0, 0, 0, 4'd0);
      syn_reset = 1'b0;
      chk("idle_after_reset", 0, 1, 0, 0, 0, 4'd0);

      // Grant: press during GREEN, then RED entry
      ped_button = 1'b1;
      cyc();
      chk("pend_edge2", 0, 1, 0, 0, 0, 4'd0);
      chk("pend_edge3", 0, 1, 1, 0, 0, 4'd0);
      ped_button = 1'b0;
      tf = RED;
      chk("grant", 1, 0, 0, 1, 0, 4'd8);

      // Countdown through WALK and FLASH
      tick = 1'b1;
      for (int k = 1; k <= 7; k++) chk("walk_count", 1, 0, 0, 1, 0, 4'(8 - k));
      chk("enter_flash", 0, 1, 0, 1, 0, 4'd6);
      tick = 1'b0;
      chk("flash_hold_no_tick", 0, 1, 0, 1, 0, 4'd6);
      tick = 1'b1;
      for (int k = 1; k <= 5; k++) chk("flash_count", 0, logic'(k % 2 == 0), 0, 1, 0, 4'(6 - k));
      chk("flash_done", 0, 1, 0, 0, 0, 4'd0);
      chk("idle_tick_ignored", 0, 1, 0, 0, 0, 4'd0);
      tick = 1'b0;

      // Abort at remaining=5 with a same-cycle tick
      tf = GREEN;
      ped_button = 1'b1;
      cyc();
      cyc();
      chk("abort_pend", 0, 1, 1, 0, 0, 4'd0);
      ped_button = 1'b0;
      tf = RED;
      chk("abort_grant", 1, 0, 0, 1, 0, 4'd8);
      tick = 1'b1;
      for (int k = 1; k <= 3; k++) chk("abort_walk", 1, 0, 0, 1, 0, 4'(8 - k));
      tf = GREEN;
      chk("abort", 0, 1, 0, 0, 1, 4'd0);
      tick = 1'b0;
      chk("conflict_one_cycle", 0, 1, 0, 0, 0, 4'd0);

      // Re-request during FLASH with button held 50 cycles
      ped_button = 1'b1;
      cyc();
      cyc();
      chk("rereq_pend", 0, 1, 1, 0, 0, 4'd0);
      ped_button = 1'b0;
      tf = RED;
      chk("rereq_grant", 1, 0, 0, 1, 0, 4'd8);
      tick = 1'b1;
      for (int k = 1; k <= 7; k++) cyc();
      chk("rereq_flash", 0, 1, 0, 1, 0, 4'd6);
      tick = 1'b0;
      ped_button = 1'b1;
      cyc();
      cyc();
      chk("flash_press_pend", 0, 1, 1, 1, 0, 4'd6);
      for (int k = 4; k <= 50; k++) cyc();
      chk("held_still_flash", 0, 1, 1, 1, 0, 4'd6);
      tick = 1'b1;
      for (int k = 1; k <= 5; k++) cyc();
      chk("no_serve_in_red", 0, 1, 1, 0, 0, 4'd0);
      tick = 1'b0;
      ped_button = 1'b0;
      cyc();
      tf = GREEN;
      chk("wait_green", 0, 1, 1, 0, 0, 4'd0);
      tf = RED;
      chk("served_at_red_entry", 1, 0, 0, 1, 0, 4'd8);
      tf = GREEN;
      chk("served_abort", 0, 1, 0, 0, 1, 4'd0);
      tf = RED;
      chk("single_req_only", 0, 1, 0, 0, 0, 4'd0);

      // Grant / button-edge collision
      tf = GREEN;
      ped_button = 1'b1;
      cyc();
      cyc();
      chk("coll_pend", 0, 1, 1, 0, 0, 4'd0);
      ped_button = 1'b0;
      cyc();
      cyc();
      cyc();
      ped_button = 1'b1;
      cyc();
      cyc();
      tf = RED;
      chk("coll_grant", 1, 0, 0, 1, 0, 4'd8);
      chk("coll_absorbed", 1, 0, 0, 1, 0, 4'd8);

      // Reset in the middle of WALK
      ped_button = 1'b0;
      tick = 1'b1;
      chk("pre_reset_walk", 1, 0, 0, 1, 0, 4'd7);
      syn_reset = 1'b1;
      chk("reset_mid_walk", 0, 1, 0, 0, 0, 4'd0);
      syn_reset = 1'b0;
      tick = 1'b0;
      chk("post_reset_no_entry", 0, 1, 0, 0, 0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
